// File: rtl/wb_vic.sv
// Vectored interrupt controller: collects level requests, raises virq, answers the
// CPU vector fetch (istb/ivec/iack) and pulses a one-hot grant to the served device.
// Optional VIC_ROUND_ROBIN_EN replaces fixed priority with a rotating pointer.
//
// state | meaning
// IDLE  | virq follows |ireq, wait for istb
// LATCH | arbitrate once, load ivec, pulse igrant
// ACK   | iack high while istb held, ivec stable
// HOLD  | one quiet cycle so the served device can drop its request
module wb_vic #(
    parameter int          N     = 4,
    parameter logic [15:0] NOVEC = 16'o000000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic [N-1:0]    ireq,
    input  logic [16*N-1:0] vec_list,
    output logic            virq,
    input  logic            istb,
    output logic [15:0]     ivec,
    output logic            iack,
    output logic [N-1:0]    igrant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        ACK   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           virq_d;
    logic [15:0]    ivec_d;
    logic           iack_d;
    logic [N-1:0]   igrant_d;

    logic           win_found;
    logic [N-1:0]   win_oh;
    logic [15:0]    win_vec;

`ifdef VIC_ROUND_ROBIN_EN
    localparam int            IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW:0]   N_W = (IW+1)'(N);

    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  win_idx;
    logic [IW:0]    cand_sum;
    logic [IW:0]    ptr_inc;

    // Scan offsets from the far end so the smallest offset from the pointer wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand_sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand_sum >= N_W) begin
                cand_sum = cand_sum - N_W;
            end
            if (ireq[cand_sum[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[IW-1:0];
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = win_found;
    end

    always_comb begin
        ptr_inc = {1'b0, win_idx} + (IW+1)'(1);
        if (ptr_inc >= N_W) begin
            ptr_inc = '0;
        end
    end
`else
    // Two's-complement trick isolates the lowest set request bit.
    always_comb begin
        win_found = |ireq;
        win_oh    = ireq & (~ireq + N'(1));
    end
`endif

    always_comb begin
        win_vec = '0;
        for (int k = 0; k < N; k++) begin
            if (win_oh[k]) begin
                win_vec = win_vec | vec_list[16*k +: 16];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        virq_d   = 1'b0;
        ivec_d   = ivec;
        iack_d   = 1'b0;
        igrant_d = '0;
`ifdef VIC_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                virq_d = |ireq;
                if (istb) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                state_d = ACK;
                if (win_found) begin
                    ivec_d   = {win_vec[15:1], 1'b0};
                    igrant_d = win_oh;
`ifdef VIC_ROUND_ROBIN_EN
                    ptr_d    = ptr_inc[IW-1:0];
`endif
                end else begin
                    ivec_d = NOVEC;
                end
            end
            ACK: begin
                if (istb) begin
                    iack_d = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            virq    <= 1'b0;
            ivec    <= '0;
            iack    <= 1'b0;
            igrant  <= '0;
`ifdef VIC_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            virq    <= virq_d;
            ivec    <= ivec_d;
            iack    <= iack_d;
            igrant  <= igrant_d;
`ifdef VIC_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_vic.sv
// Bench for wb_vic: directed scenarios plus randomized interrupt transactions
// checked against a transaction-level reference model (fixed or round-robin).
module tb_wb_vic;

    localparam int          N     = 4;
    localparam logic [15:0] NOVEC = 16'o000774;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_n;
    logic [N-1:0]    ireq;
    logic [16*N-1:0] vec_list;
    logic            virq;
    logic            istb;
    logic [15:0]     ivec;
    logic            iack;
    logic [N-1:0]    igrant;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] vecs [N];
`ifdef VIC_ROUND_ROBIN_EN
    int ptr = 0;
`endif

    wb_vic #(.N(N), .NOVEC(NOVEC)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .ireq     (ireq),
        .vec_list (vec_list),
        .virq     (virq),
        .istb     (istb),
        .ivec     (ivec),
        .iack     (iack),
        .igrant   (igrant)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic load_vecs();
        for (int k = 0; k < N; k++) begin
            vec_list[16*k +: 16] = vecs[k];
        end
    endtask

    // Winner as the rules state it: lowest set index, or first set index at/after pointer.
    function automatic int pick(input logic [N-1:0] r);
`ifdef VIC_ROUND_ROBIN_EN
        for (int i = 0; i < N; i++) begin
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (r[k]) return k;
        end
`endif
        return -1;
    endfunction

    // One full interrupt transaction starting and ending in IDLE.
    task automatic txn(input logic [N-1:0] req, input logic [N-1:0] req_latch,
                       input int hold, output int won);
        logic [15:0]  exp_vec;
        logic [N-1:0] exp_oh;
        ireq = req;
        istb = 1'b0;
        tick();
        check("virq_idle", 32'(virq), 32'(|req));
        ireq = req_latch;
        istb = 1'b1;
        tick();
        check("virq_stb", 32'(virq), 32'(|req_latch));
        check("iack_early", 32'(iack), 32'(0));
        won = pick(req_latch);
        if (won < 0) begin
            exp_vec = NOVEC;
            exp_oh  = '0;
        end else begin
            exp_vec = vecs[won] & 16'hFFFE;
            exp_oh  = N'(1) << won;
`ifdef VIC_ROUND_ROBIN_EN
            ptr = (won + 1) % N;
`endif
        end
        istb = 1'($urandom_range(0, 1));
        tick();
        check("ivec_latch", 32'(ivec), 32'(exp_vec));
        check("igrant", 32'(igrant), 32'(exp_oh));
        check("virq_latch", 32'(virq), 32'(0));
        check("iack_latch", 32'(iack), 32'(0));
        for (int c = 0; c < hold; c++) begin
            istb = 1'b1;
            ireq = N'($urandom);
            tick();
            check("iack_hold", 32'(iack), 32'(1));
            check("ivec_hold", 32'(ivec), 32'(exp_vec));
            check("igrant_once", 32'(igrant), 32'(0));
            check("virq_ack", 32'(virq), 32'(0));
        end
        istb = 1'b0;
        ireq = N'($urandom);
        tick();
        check("iack_drop", 32'(iack), 32'(0));
        check("ivec_drop", 32'(ivec), 32'(exp_vec));
        check("virq_to_hold", 32'(virq), 32'(0));
        ireq = N'($urandom) | N'(1);
        tick();
        check("virq_hold", 32'(virq), 32'(0));
        check("iack_hold_st", 32'(iack), 32'(0));
    endtask

    initial begin
        int won;
        logic [N-1:0] r;
        logic [N-1:0] r2;
        logic [15:0]  stuck_vec;
        int cnt3;

        wb_rst_n = 1'b0;
        istb     = 1'b0;
        ireq     = '0;
        for (int k = 0; k < N; k++) vecs[k] = 16'($urandom);
        load_vecs();
        #12;
        check("rst_virq", 32'(virq), 32'(0));
        check("rst_ivec", 32'(ivec), 32'(0));
        check("rst_iack", 32'(iack), 32'(0));
        check("rst_igrant", 32'(igrant), 32'(0));
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;

        // single source, strobe three cycles after the request
        vecs[2] = 16'o000300;
        load_vecs();
        ireq = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("virq_single", 32'(virq), 32'(1));
        end
        txn(4'b0100, 4'b0100, 2, won);
        check("single_won", 32'(won), 32'(2));

        // priority, device clears its bit on grant
        r = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            txn(r, r, 1, won);
            if (won >= 0) r[won] = 1'b0;
        end

        // withdrawn request: one-cycle pulse, strobe after it drops
        txn(4'b0100, 4'b0000, 1, won);
        check("withdrawn_won", 32'(won), 32'(-1));

        // odd vector has bit 0 forced low
        vecs[0] = 16'o000061;
        load_vecs();
        txn(4'b0001, 4'b0001, 1, won);
        check("odd_vec", 32'(ivec), 32'(16'o000060));

        // stuck strobe then reset in the middle of ACK
        ireq = 4'b0010;
        istb = 1'b1;
        tick();
        tick();
        stuck_vec = vecs[1] & 16'hFFFE;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("stuck_iack", 32'(iack), 32'(1));
            check("stuck_ivec", 32'(ivec), 32'(stuck_vec));
        end
        #2;
        wb_rst_n = 1'b0;
        #1;
        check("arst_iack", 32'(iack), 32'(0));
        check("arst_virq", 32'(virq), 32'(0));
        check("arst_ivec", 32'(ivec), 32'(0));
        check("arst_igrant", 32'(igrant), 32'(0));
`ifdef VIC_ROUND_ROBIN_EN
        ptr = 0;
`endif
        tick();
        check("arst_hold_ivec", 32'(ivec), 32'(0));
        istb = 1'b0;
        ireq = '0;
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        txn(4'b0110, 4'b0110, 1, won);

        // starvation: source 0 re-asserts immediately, source 3 stays pending
        cnt3 = 0;
        r = 4'b1001;
        for (int i = 0; i < 2; i++) begin
            txn(r, r, 1, won);
            if (won == 3) begin
                cnt3++;
                r = 4'b0001;
            end
        end
`ifdef VIC_ROUND_ROBIN_EN
        check("starve_rr", 32'(cnt3), 32'(1));
`else
        check("starve_fixed", 32'(cnt3), 32'(0));
`endif

        // randomized transactions
        r = N'($urandom);
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < N; k++) vecs[k] = 16'($urandom);
                load_vecs();
            end
            case ($urandom_range(0, 5))
                0:       r2 = '0;
                1:       r2 = N'($urandom);
                default: r2 = r;
            endcase
            txn(r, r2, int'($urandom_range(0, 4)), won);
            r = r2;
            if (won >= 0) r[won] = 1'b0;
            if ($urandom_range(0, 2) == 0) r = r | N'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
